// File: rtl/ariane_pkg.sv
// Shared types for the D-cache performance event generator: event indices, AMO FSM states
// and the per-port lookup classifier.
package ariane_pkg;

  localparam int unsigned DC_PERF_NUM_EVT = 7;

  typedef enum logic [2:0] {
    DcEvtMiss,
    DcEvtHit,
    DcEvtWriteHitUnique,
    DcEvtWriteHitShared,
    DcEvtWriteMiss,
    DcEvtCleanInvalidHit,
    DcEvtCleanInvalidMiss
  } dc_perf_evt_e;

  typedef enum logic {
    AmoIdle,
    AmoBusy
  } amo_state_e;

  // Store hits also count as hits and store misses also count as misses.
  function automatic logic [DC_PERF_NUM_EVT-1:0] dc_perf_classify(
    input logic hit,
    input logic we,
    input logic shared,
    input logic cinv
  );
    logic [DC_PERF_NUM_EVT-1:0] evt;
    evt = '0;
    if (cinv) begin
      evt[DcEvtCleanInvalidHit]  = hit;
      evt[DcEvtCleanInvalidMiss] = ~hit;
    end else begin
      evt[DcEvtHit]  = hit;
      evt[DcEvtMiss] = ~hit;
      if (we) begin
        evt[DcEvtWriteHitUnique] = hit & ~shared;
        evt[DcEvtWriteHitShared] = hit & shared;
        evt[DcEvtWriteMiss]      = ~hit;
      end
    end
    return evt;
  endfunction

endpackage

// File: rtl/perf_evt_pending.sv
// One event channel: turns a per-cycle event count into single-cycle pulses.
// With DCACHE_PERF_PENDING_EN a saturating backlog counter spreads coincident events over cycles.
module perf_evt_pending
  import ariane_pkg::*;
#(
  parameter int unsigned PendW = 3,
  parameter int unsigned CntW  = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [CntW-1:0] n_new_i,
  output logic            pulse_o,
  output logic            drop_o
);

  logic pulse_d, pulse_q;

`ifdef DCACHE_PERF_PENDING_EN
  localparam int unsigned SumW = PendW + CntW;
  localparam logic [SumW-1:0] PMax = SumW'((1 << PendW) - 1);

  logic [PendW-1:0] pend_q, pend_d;
  logic [SumW-1:0]  total, remain;

  always_comb begin
    total   = SumW'(pend_q) + SumW'(n_new_i);
    pulse_d = (total != '0);
    remain  = total - SumW'(pulse_d);
    drop_o  = (remain > PMax);
    pend_d  = drop_o ? PMax[PendW-1:0] : remain[PendW-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end
`else
  // Without a backlog, coincident events collapse into one pulse and the rest are lost.
  assign pulse_d = (n_new_i != '0);
  assign drop_o  = (n_new_i > CntW'(1));

  if (PendW == 0) begin : g_bad_cfg
    $fatal(1, "perf_evt_pending: PendW must be nonzero");
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/dcache_perf_event_gen.sv
// D-cache performance event generator: classifies lookups into seven event pulses,
// registers the flush level and tracks outstanding AMOs. Optional feature: DCACHE_PERF_PENDING_EN.
module dcache_perf_event_gen
  import ariane_pkg::*;
#(
  parameter int unsigned NumPorts = 3,
  parameter int unsigned PendW    = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumPorts-1:0] lookup_valid_i,
  input  logic [NumPorts-1:0] lookup_hit_i,
  input  logic [NumPorts-1:0] lookup_we_i,
  input  logic [NumPorts-1:0] lookup_shared_i,
  input  logic [NumPorts-1:0] lookup_cinv_i,
  input  logic                flush_i,
  input  logic                amo_req_i,
  input  logic                amo_ack_i,
  output logic                l1_dcache_miss_o,
  output logic                l1_dcache_hit_o,
  output logic                l1_dcache_write_hit_unique_o,
  output logic                l1_dcache_write_hit_shared_o,
  output logic                l1_dcache_write_miss_o,
  output logic                l1_dcache_clean_invalid_hit_o,
  output logic                l1_dcache_clean_invalid_miss_o,
  output logic                l1_dcache_flushing_o,
  output logic                amo_o,
  output logic                evt_lost_o
);

  localparam int unsigned CntW = $clog2(NumPorts + 1);

  logic [DC_PERF_NUM_EVT-1:0] port_evt;
  logic [CntW-1:0]            n_new [DC_PERF_NUM_EVT];
  logic [DC_PERF_NUM_EVT-1:0] pulse, drop;
  logic                       evt_lost_d, evt_lost_q;
  logic                       flushing_q;
  amo_state_e                 amo_state_q;
  logic                       amo_q;

  always_comb begin
    port_evt = '0;
    for (int e = 0; e < DC_PERF_NUM_EVT; e++) begin
      n_new[e] = '0;
    end
    for (int p = 0; p < NumPorts; p++) begin
      port_evt = lookup_valid_i[p] ?
                 dc_perf_classify(lookup_hit_i[p], lookup_we_i[p], lookup_shared_i[p],
                                  lookup_cinv_i[p]) : '0;
      for (int e = 0; e < DC_PERF_NUM_EVT; e++) begin
        n_new[e] = n_new[e] + CntW'(port_evt[e]);
      end
    end
  end

  for (genvar g = 0; g < DC_PERF_NUM_EVT; g++) begin : g_evt
    perf_evt_pending #(
      .PendW(PendW),
      .CntW (CntW)
    ) u_pend (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .n_new_i(n_new[g]),
      .pulse_o(pulse[g]),
      .drop_o (drop[g])
    );
  end

  assign evt_lost_d = evt_lost_q | (|drop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      evt_lost_q <= 1'b0;
      flushing_q <= 1'b0;
    end else begin
      evt_lost_q <= evt_lost_d;
      flushing_q <= flush_i;
    end
  end

  // A request acknowledged in the same cycle never becomes outstanding.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      amo_state_q <= AmoIdle;
      amo_q       <= 1'b0;
    end else begin
      unique case (amo_state_q)
        AmoIdle: begin
          if (amo_req_i && !amo_ack_i) begin
            amo_state_q <= AmoBusy;
            amo_q       <= 1'b1;
          end
        end
        AmoBusy: begin
          if (amo_ack_i) begin
            amo_state_q <= AmoIdle;
            amo_q       <= 1'b0;
          end
        end
      endcase
    end
  end

  assign l1_dcache_miss_o               = pulse[DcEvtMiss];
  assign l1_dcache_hit_o                = pulse[DcEvtHit];
  assign l1_dcache_write_hit_unique_o   = pulse[DcEvtWriteHitUnique];
  assign l1_dcache_write_hit_shared_o   = pulse[DcEvtWriteHitShared];
  assign l1_dcache_write_miss_o         = pulse[DcEvtWriteMiss];
  assign l1_dcache_clean_invalid_hit_o  = pulse[DcEvtCleanInvalidHit];
  assign l1_dcache_clean_invalid_miss_o = pulse[DcEvtCleanInvalidMiss];
  assign l1_dcache_flushing_o           = flushing_q;
  assign amo_o                          = amo_q;
  assign evt_lost_o                     = evt_lost_q;

endmodule
